// File: rtl/data_mem_responder.sv
// Multi-cycle data memory target: captures a load/store request, waits LATENCY cycles,
// commits (read-before-write) and pulses a one-cycle response.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request captured, counting down to commit
// RESP  | response pulse cycle
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [1:0]        req_read_i,
  input  logic [1:0]        req_write_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              busy_o
);

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;
  localparam int         DEPTH   = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        rsz_q, wsz_q;
  logic [31:0]       rdata_q;
  logic              capture, commit;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       mem_word, load_word, store_word;
  logic              req_has_op;

  assign req_has_op = (req_read_i == SZ_BYTE) || (req_read_i == SZ_HALF) || (req_read_i == SZ_WORD) ||
                      (req_write_i == SZ_BYTE) || (req_write_i == SZ_HALF) || (req_write_i == SZ_WORD);

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    capture     = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i && req_has_op) begin
          capture   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_word = mem[addr_q];

  always_comb begin
    load_word = 32'h0;
    case (rsz_q)
      SZ_WORD: load_word = mem_word;
      SZ_HALF: load_word = {{16{mem_word[15]}}, mem_word[15:0]};
      SZ_BYTE: load_word = {{24{mem_word[7]}}, mem_word[7:0]};
      default: load_word = 32'h0;
    endcase
  end

  // Partial stores merge into the current word so upper bits survive.
  always_comb begin
    store_word = mem_word;
    case (wsz_q)
      SZ_WORD: store_word = wdata_q;
      SZ_HALF: store_word = {mem_word[31:16], wdata_q[15:0]};
      SZ_BYTE: store_word = {mem_word[31:8], wdata_q[7:0]};
      default: store_word = mem_word;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rsz_q   <= 2'b00;
      wsz_q   <= 2'b00;
      rdata_q <= 32'h0;
    end else begin
      if (capture) begin
        cnt     <= 4'(LATENCY);
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        rsz_q   <= req_read_i;
        wsz_q   <= req_write_i;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) rdata_q <= load_word;
    end
  end

  // No reset on the array; an abandoned request never reaches commit.
  always_ff @(posedge clk_i) begin
    if (commit && (wsz_q != 2'b00)) mem[addr_q] <= store_word;
  end

  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: LATENCY=2 instance for directed tests and
// a LATENCY=0 instance for back-to-back streaming.
module tb_data_mem_responder;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] BYTE = 2'b01;
  localparam logic [1:0] HALF = 2'b10;
  localparam logic [1:0] WORD = 2'b11;
  localparam int LAT = 2;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  exp_t q2[$];
  exp_t q0[$];

  logic        valid = 1'b0, ready, rsp_valid, busy;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [1:0]  rsz = NONE, wsz = NONE;

  logic        v0_valid = 1'b0, v0_ready, v0_rsp_valid, v0_busy;
  logic [7:0]  v0_addr = '0;
  logic [31:0] v0_wdata = '0, v0_rdata;
  logic [1:0]  v0_rsz = NONE, v0_wsz = NONE;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
    .clk_i(clk), .n_rst_i(n_rst), .req_valid_i(valid), .req_ready_o(ready),
    .req_addr_i(addr), .req_wdata_i(wdata), .req_read_i(rsz), .req_write_i(wsz),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rdata), .busy_o(busy)
  );

  data_mem_responder #(.ADDR_W(8), .LATENCY(0)) dut0 (
    .clk_i(clk), .n_rst_i(n_rst), .req_valid_i(v0_valid), .req_ready_o(v0_ready),
    .req_addr_i(v0_addr), .req_wdata_i(v0_wdata), .req_read_i(v0_rsz), .req_write_i(v0_wsz),
    .rsp_valid_o(v0_rsp_valid), .rsp_rdata_o(v0_rdata), .busy_o(v0_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (q2.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        check("rdata", rdata, e.data);
        check("rsp_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (v0_rsp_valid) begin
      if (q0.size() == 0) begin
        check("l0_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        check("l0_rdata", v0_rdata, e.data);
        check("l0_rsp_cycle", cyc, e.due);
      end
    end
  end

  // One request on the LATENCY=2 instance; inputs are scrambled right after acceptance.
  task automatic do_req(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r,
                        input logic [1:0] w, input logic [31:0] exp);
    int n;
    exp_t e;
    @(negedge clk);
    check("ready_before_req", ready, 1'b1);
    valid = 1'b1; addr = a; wdata = d; rsz = r; wsz = w;
    @(posedge clk); #1;
    e.data = exp; e.due = cyc + LAT + 1;
    q2.push_back(e);
    valid = 1'b0; addr = ~a; wdata = ~d; rsz = WORD; wsz = WORD;
    n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      if (!busy) check("busy_while_not_ready", busy, 1'b1);
      n++;
      @(negedge clk);
    end
    check("ready_low_cycles", n, LAT + 2);
  endtask

  logic [1:0]  s_rsz [5] = '{NONE, WORD, BYTE, HALF, WORD};
  logic [1:0]  s_wsz [5] = '{WORD, NONE, NONE, HALF, NONE};
  logic [31:0] s_wd  [5] = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h00008001, 32'h0};
  logic [31:0] s_exp [5] = '{32'h0, 32'hCAFEF00D, 32'h0000000D, 32'hFFFFF00D, 32'hCAFE8001};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int n;
    @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    n_rst = 1'b1;

    do_req(8'h10, 32'h00000000, NONE, WORD, 32'h0);
    do_req(8'h04, 32'h12345678, NONE, WORD, 32'h0);
    do_req(8'h04, 32'h0,        WORD, NONE, 32'h12345678);
    do_req(8'h20, 32'h11223344, NONE, WORD, 32'h0);
    do_req(8'h20, 32'h000000F0, NONE, BYTE, 32'h0);
    do_req(8'h20, 32'h0,        WORD, NONE, 32'h112233F0);
    do_req(8'h20, 32'h0,        BYTE, NONE, 32'hFFFFFFF0);
    do_req(8'h20, 32'h0,        HALF, NONE, 32'h000033F0);

    // Reset one cycle after accepting a store: the store must never land.
    @(negedge clk);
    valid = 1'b1; addr = 8'h10; wdata = 32'hDEADBEEF; rsz = NONE; wsz = WORD;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    check("midrst_ready", ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    do_req(8'h10, 32'h0, WORD, NONE, 32'h00000000);

    do_req(8'h08, 32'hAAAA5555, NONE, WORD, 32'h0);
    do_req(8'h08, 32'h00000000, WORD, WORD, 32'hAAAA5555);
    do_req(8'h08, 32'h0,        WORD, NONE, 32'h00000000);

    @(negedge clk);
    valid = 1'b1; addr = 8'h30; wdata = 32'h55; rsz = NONE; wsz = NONE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("null_ready", ready, 1'b1);
      check("null_busy", busy, 1'b0);
      check("null_rsp_valid", rsp_valid, 1'b0);
    end
    valid = 1'b0;

    // LATENCY=0 instance: valid held high, next request presented right after each response.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("l0_ready_idle", v0_ready, 1'b1);
      check("l0_busy_idle", v0_busy, 1'b0);
      v0_valid = 1'b1; v0_addr = 8'h05; v0_wdata = s_wd[i]; v0_rsz = s_rsz[i]; v0_wsz = s_wsz[i];
      @(posedge clk); #1;
      e.data = s_exp[i]; e.due = cyc + 1;
      q0.push_back(e);
      @(negedge clk);
      check("l0_busy_wait", v0_busy, 1'b1);
      check("l0_ready_wait", v0_ready, 1'b0);
      @(negedge clk);
      check("l0_busy_resp", v0_busy, 1'b1);
      check("l0_ready_resp", v0_ready, 1'b0);
    end
    v0_valid = 1'b0;

    n = 0;
    while ((q2.size() != 0 || q0.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("q2_drained", q2.size(), 0);
    check("q0_drained", q0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory target serving load/store requests from the MEM pipeline stage over a valid/ready request and one-cycle response-pulse interface.
- Replaces the zero-latency ideal data memory so stall logic can be exercised.
- Sits between the MEM stage, the request initiator, and the hazard/stall unit, which consumes busy_o.
- Access-size semantics are identical to the pipeline's existing `WORD / `HALFWORD / `BYTE codes from header.v.

Parameters:
- ADDR_W, 8, word-address width; memory depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, number of wait cycles between acceptance and commit/response; legal range 0..15.

Ports:
- clk_i  input  1  single clock; all state updates on posedge.
- n_rst_i  input  1  asynchronous active-low reset.
- req_valid_i  input  1  initiator presents a request.
- req_ready_o  output  1  responder can accept a request this cycle.
- req_addr_i  input  ADDR_W  word address.
- req_wdata_i  input  32  store data.
- req_read_i  input  2  load size code (`WORD/`HALFWORD/`BYTE; any other code = no load).
- req_write_i  input  2  store size code (same encoding; other = no store).
- rsp_valid_o  output  1  one-cycle pulse: request completed.
- rsp_rdata_o  output  32  load result, sign-extended.
- busy_o  output  1  high whenever a request is in flight (state != IDLE).

Behaviour:
- Reset (async, n_rst_i=0):
  - State goes to IDLE and the counter clears.
  - req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, busy_o=0.
  - Memory array is not cleared.
  - Reset mid-request abandons it; a store that has not yet committed is never written.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - Acceptance occurs on a posedge with req_valid_i=1 and at least one size code valid.
  - On acceptance: capture addr, wdata, read size and write size; load cnt=LATENCY; go to WAIT.
  - A valid request with both codes invalid is ignored: no state change, ready stays 1.
- WAIT:
  - req_ready_o=0, busy_o=1.
  - If cnt!=0: decrement cnt.
  - If cnt==0: commit and go to RESP.
  - Commit means:
    - Read the captured word and produce the sign-extended result into rsp_rdata_o.
    - Perform the store on the same edge.
    - `HALFWORD store replaces bits [15:0] only; `BYTE store replaces bits [7:0] only; upper bits are preserved.
- RESP:
  - rsp_valid_o=1 for exactly this cycle; req_ready_o=0; busy_o=1.
  - Next edge goes to IDLE unconditionally.
- Latency and throughput:
  - Acceptance at edge T gives rsp_valid_o high during the cycle after edge T+LATENCY+1.
  - The next acceptance is possible at edge T+LATENCY+3 at the earliest.
  - With LATENCY=0: response during the cycle after edge T+1.
- Load data formatting:
  - `WORD returns the word unchanged.
  - `HALFWORD returns {16{d[15]}, d[15:0]}.
  - `BYTE returns {24{d[7]}, d[7:0]}.
  - A store-only request returns rsp_rdata_o=0.
- Load and store in the same request: the load returns the pre-store contents (read-before-write); the store then commits.
- A subsequent load to the same address sees the committed store.
- rsp_rdata_o holds its value until the next commit.
- Request inputs are ignored outside IDLE.
- Changes to the inputs after acceptance do not affect the in-flight request.
- Address range: the full 0..2**ADDR_W-1 range is valid; there is no wrap or out-of-range case.

Test Plan:
- Reset mid-WAIT:
  - Store `WORD 0xDEADBEEF to addr 0x10 with LATENCY=2; assert n_rst_i low one cycle after acceptance.
  - Required: outputs return to reset values immediately; a later `WORD load of 0x10 returns its prior value (preloaded 0x00000000), not 0xDEADBEEF.
- Word store then load:
  - Store `WORD 0x12345678 at addr 0x04, then load `WORD at addr 0x04.
  - Required: rsp_valid_o pulses exactly LATENCY+1 cycles after each acceptance edge; load returns 0x12345678; req_ready_o is low for LATENCY+2 cycles per request.
- Partial stores:
  - Preload 0x11223344 at 0x20; store `BYTE 0x000000F0; load `WORD.
  - Required: 0x112233F0. Then load `BYTE: 0xFFFFFFF0. Then load `HALFWORD: 0x000033F0.
- Read-before-write:
  - Addr 0x08 holds 0xAAAA5555; one request with load `WORD and store `WORD 0x0.
  - Required: rsp_rdata_o=0xAAAA5555; a following load returns 0x00000000.
- Null request and input hold:
  - req_valid_i=1 with both size codes invalid: required ready stays 1, busy_o stays 0, no rsp_valid_o.
  - Change req_addr_i and req_wdata_i during WAIT: required the captured values are used.
- LATENCY=0 build, back-to-back requests with req_valid_i held high:
  - Required: responses one cycle after each acceptance edge; acceptances every 3 cycles; busy_o low only in IDLE cycles.
